// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, MSB first,
// with sign fix-up after the magnitude loop and an enabled/completed handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for enabled; operands captured on the accept edge
// S_BUSY | WIDTH iterations of shift/subtract on magnitudes
// S_FIX  | apply quotient/remainder signs, raise completed
// S_DONE | result held while enabled stays high
module seq_divider #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enabled,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] r,
   output logic             completed
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q,     state_d;
   logic [CW-1:0]    count_q,     count_d;
   logic [WIDTH-1:0] rem_q,       rem_d;
   logic [WIDTH-1:0] quo_q,       quo_d;
   logic [WIDTH-1:0] div_q,       div_d;
   logic             qsign_q,     qsign_d;
   logic             rsign_q,     rsign_d;
   logic [WIDTH-1:0] c_q,         c_d;
   logic [WIDTH-1:0] r_q,         r_d;
   logic             completed_q, completed_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             last_iter;

   assign a_neg = SIGNED & a[WIDTH-1];
   assign b_neg = SIGNED & b[WIDTH-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   // Remainder is always below the divisor, so WIDTH stored bits suffice;
   // the shifted value needs one extra bit and the sign of the difference
   // lands in bit WIDTH.
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, div_q};
   assign last_iter = (count_q == CW'(WIDTH - 1));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      div_d       = div_q;
      qsign_d     = qsign_q;
      rsign_d     = rsign_q;
      c_d         = c_q;
      r_d         = r_q;
      completed_d = completed_q;

      unique case (state_q)
         S_IDLE: begin
            completed_d = 1'b0;
            if (enabled) begin
               qsign_d = a_neg ^ b_neg;
               rsign_d = a_neg;
               count_d = '0;
               rem_d   = '0;
               quo_d   = a_mag;
               div_d   = b_mag;
               if (b == '0) begin
                  c_d     = '1;
                  r_d     = a;
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            if (!enabled) begin
               state_d = S_IDLE;
            end else begin
               count_d = count_q + CW'(1);
               if (!rem_diff[WIDTH]) begin
                  rem_d = rem_diff[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_shift[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               if (last_iter) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            if (!enabled) begin
               state_d = S_IDLE;
            end else begin
               c_d         = qsign_q ? (~quo_q + 1'b1) : quo_q;
               r_d         = rsign_q ? (~rem_q + 1'b1) : rem_q;
               completed_d = 1'b1;
               state_d     = S_DONE;
            end
         end

         S_DONE: begin
            // Divide-by-zero enters here with completed low; it rises one
            // edge later, so a request always sees at least one low sample.
            completed_d = enabled;
            if (!enabled) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         c_q         <= '0;
         r_q         <= '0;
         completed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         div_q       <= div_d;
         qsign_q     <= qsign_d;
         rsign_q     <= rsign_d;
         c_q         <= c_d;
         r_q         <= r_d;
         completed_q <= completed_d;
      end
   end

   assign c         = c_q;
   assign r         = r_q;
   assign completed = completed_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, abort/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_s, en_u;
   logic [31:0] a_s, b_s, a_u, b_u;
   logic [31:0] c_s, r_s, c_u, r_u;
   logic        cmp_s, cmp_u;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(32), .SIGNED(1'b1)) u_signed (
      .clk(clk), .reset(rst), .enabled(en_s), .a(a_s), .b(b_s),
      .c(c_s), .r(r_s), .completed(cmp_s)
   );

   seq_divider #(.WIDTH(32), .SIGNED(1'b0)) u_unsigned (
      .clk(clk), .reset(rst), .enabled(en_u), .a(a_u), .b(b_u),
      .c(c_u), .r(r_u), .completed(cmp_u)
   );

   typedef struct {
      bit          uns;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit uns, input logic en, input logic [31:0] x, input logic [31:0] y);
      if (uns) begin
         en_u = en; a_u = x; b_u = y;
      end else begin
         en_s = en; a_s = x; b_s = y;
      end
   endtask

   task automatic sample(input bit uns, output logic [31:0] cc, output logic [31:0] rr, output logic cm);
      cc = uns ? c_u : c_s;
      rr = uns ? r_u : r_s;
      cm = uns ? cmp_u : cmp_s;
   endtask

   // Reference: plain integer division; 64-bit signed arithmetic makes
   // MIN / -1 produce +2^31, which truncates back to MIN.
   task automatic model(input bit uns, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] qc, output logic [31:0] qr, output int lat);
      longint sx, sy;
      if (y == 32'd0) begin
         qc = 32'hFFFF_FFFF; qr = x; lat = 1;
      end else if (uns) begin
         qc = x / y; qr = x % y; lat = 33;
      end else begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         qc = 32'(sx / sy); qr = 32'(sx % sy); lat = 33;
      end
   endtask

   task automatic run_op(input string name, input bit uns, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ec, input logic [31:0] er, input int elat, input int hold);
      logic [31:0] cc, rr;
      logic        cm;
      int          n;
      bit          seen;
      set_req(uns, 1'b1, x, y);
      n = 0; seen = 0;
      while (n < 40 && !seen) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) set_req(uns, 1'b1, $urandom, $urandom);
         sample(uns, cc, rr, cm);
         if (cm === 1'b1) seen = 1;
      end
      chk({name, ".lat"}, seen ? 32'(n - 1) : 32'hFFFF_FFFF, 32'(elat));
      chk({name, ".c"}, cc, ec);
      chk({name, ".r"}, rr, er);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         sample(uns, cc, rr, cm);
         chk({name, ".hold"}, {31'd0, cm}, 32'd1);
      end
      set_req(uns, 1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      sample(uns, cc, rr, cm);
      chk({name, ".drop"}, {31'd0, cm}, 32'd0);
   endtask

   initial begin
      logic [31:0] x, y, ec, er;
      int          el;
      bit          uns, seen;

      vecs[0] = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      vecs[1] = '{0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33};
      vecs[2] = '{0, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          33};
      vecs[3] = '{0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1};
      vecs[4] = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      vecs[5] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
      vecs[6] = '{0, 32'd7,          32'd2,          32'd3,          32'd1,          33};
      vecs[7] = '{0, 32'd8,          32'd4,          32'd2,          32'd0,          33};
      vecs[8] = '{1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1};
      vecs[9] = '{1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};

      rst = 1'b1;
      en_s = 1'b0; en_u = 1'b0;
      a_s = '0; b_s = '0; a_u = '0; b_u = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.cmp_s", {31'd0, cmp_s}, 32'd0);
      chk("rst.c_s", c_s, 32'd0);
      chk("rst.r_s", r_s, 32'd0);
      chk("rst.cmp_u", {31'd0, cmp_u}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].uns, vecs[i].a, vecs[i].b,
                vecs[i].c, vecs[i].r, vecs[i].lat, i % 3);

      // Abort at E10: enabled low when the 11th edge after raising arrives.
      set_req(0, 1'b1, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1 en_s = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (cmp_s !== 1'b0) seen = 1;
      end
      chk("abort.cmp", {31'd0, seen}, 32'd0);
      chk("abort.c", c_s, 32'd2);
      chk("abort.r", r_s, 32'd0);
      run_op("after_abort", 0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1);

      // Reset sampled at E5 of an in-flight operation.
      set_req(0, 1'b1, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst.cmp", {31'd0, cmp_s}, 32'd0);
      chk("midrst.c", c_s, 32'd0);
      chk("midrst.r", r_s, 32'd0);
      rst = 1'b0; en_s = 1'b0;
      @(posedge clk); #1;
      run_op("post_rst", 0, 32'd7, 32'd2, 32'd3, 32'd1, 33, 0);

      for (int i = 0; i < 60; i++) begin
         uns = 1'($urandom_range(0, 1));
         x = $urandom;
         case ($urandom_range(0, 7))
            0:       y = 32'd0;
            1:       y = 32'($urandom_range(1, 9));
            2:       y = -32'($urandom_range(1, 9));
            3:       begin x = 32'($urandom_range(0, 50)); y = $urandom; end
            default: y = $urandom;
         endcase
         model(uns, x, y, ec, er, el);
         run_op($sformatf("rnd%0d", i), uns, x, y, ec, er, el, $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
